retire_ctrl: RTL and testbench
==============================

# retire_ctrl

Commit scheduler for the out-of-order backend. Each cycle it examines the `MACHINE_WIDTH`-entry window at the ROB head and decides which entries retire, in order. It sequences branch-mispredict recovery and exception shutdown, and throttles store retirement into the store queue. It sits between `u_rob` (head window) and `u_lsq.u_stq` / frontend flush logic, and drives the `retire_valid` mask consumed by the ROB, the store queue and the dump/log monitors.

## Interface

**Parameters**
- `W`, default `MACHINE_WIDTH` (4): retire slots per cycle.
- `EXC_W`, default 4: width of the `EXCEPTION_CODE` encoding; `NO_ERROR` = 0.
- `ST_PER_CYC`, default 1: maximum stores retired per cycle.
- `DRAIN_TIMEOUT`, default 100: cycles allowed for store-queue drain after an exception.

**Ports**
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `head_valid`  in  W  ROB window entry occupied; slot 0 = ROB head.
- `head_complete`  in  W  entry has executed.
- `head_exception`  in  W×EXC_W  per-slot exception code.
- `head_is_branch`  in  W  entry is a branch.
- `head_branch_misp`  in  W  branch resolved mispredicted.
- `head_is_store`  in  W  entry is a store.
- `stq_retire_ready`  in  1  STQ can accept retire marks this cycle.
- `stq_empty`  in  1  no retired stores remain undrained.
- `flush_done`  in  1  frontend/backend flush complete.
- `retire_valid`  out  W  per-slot retire mask, combinational; always a contiguous prefix.
- `retire_cnt`  out  $clog2(W+1)  popcount of `retire_valid`; the ROB head advances by this value.
- `flush_req`  out  1  registered mispredict-recovery request.
- `halted`  out  1  registered, sticky halt.
- `halt_code`  out  EXC_W  exception code that caused the halt.
- `drain_timeout`  out  1  set if the halt was forced by timeout.
- `perf_instr_cnt`  out  64  retired instructions (see Configuration).
- `perf_br_cnt`  out  32  retired branches.
- `perf_misp_cnt`  out  32  retired mispredicted branches.

## Operation

**States:** RUN, RECOVER, DRAIN, HALT. Reset state is RUN.

**Retirement** happens only in RUN. Slot i retires iff:
- every slot below i retires;
- `head_valid[i]` and `head_complete[i]` are set;
- no earlier slot in the group ended the group;
- the count of stores in slots 0..i is ≤ `ST_PER_CYC`;
- if slot i is a store, `stq_retire_ready` is high.

**Group-ending slots:**
- The first slot with `head_exception` != 0 retires and ends the group. Next state is DRAIN; `halt_code` latches the code.
- Otherwise, the first retiring slot with `head_branch_misp` ends the group. Next state is RECOVER.
- If the same slot has both an exception and a mispredict, the exception wins.

**RECOVER**
- `flush_req` = 1 throughout.
- No retirement.
- On `flush_done` = 1, go to RUN; `flush_req` drops the same edge.

**DRAIN**
- No retirement.
- A down-counter loads `DRAIN_TIMEOUT` on entry.
- On `stq_empty`, go to HALT.
- When the counter reaches 0, go to HALT and set `drain_timeout`.
- If `stq_empty` and counter = 0 occur together, go to HALT with `drain_timeout` = 0.

**HALT**
- `halted` = 1 and no retirement until `rst`.
- `flush_done` is ignored outside RECOVER.

## Timing

- `retire_valid` / `retire_cnt` are combinational from the head window in the same cycle. There are no registered outputs on the retire path.
- State, `flush_req`, `halted`, `halt_code`, `drain_timeout` and the counters update on the `clk` edge. `flush_req` rises the cycle after the mispredict retires.
- Minimum RECOVER occupancy is 1 cycle (`flush_done` sampled in the first RECOVER cycle).
- Output reset values are all 0: `retire_valid`, `retire_cnt`, `flush_req`, `halted`, `halt_code`, `drain_timeout`, counters. State is RUN and the drain counter is 0.
- Any-cycle `rst` returns to RUN with all of the above cleared, including mid-RECOVER and mid-DRAIN.
- Counters wrap modulo 2^width.

## Configuration

- `RETIRE_PERF_EN` defined:
  - `perf_instr_cnt` += `retire_cnt` each edge.
  - `perf_br_cnt` += retiring branches.
  - `perf_misp_cnt` += retiring mispredicted branches.
- `RETIRE_PERF_EN` undefined: all three perf outputs are constant 0 and no counter flops exist.

## Test plan

- All 4 slots valid+complete, no stores, no exceptions → `retire_valid`=4'b1111, `retire_cnt`=4; state stays RUN.
- Slots 0,1,2 stores, `ST_PER_CYC`=1, `stq_retire_ready`=1 → mask 4'b0001. Same window with `stq_retire_ready`=0 → mask 4'b0000.
- Slot 1 branch with misp, slot 2 complete → mask 4'b0011; next cycle `flush_req`=1 with mask 0 until `flush_done` pulses at cycle+3; RUN resumes the cycle after.
- Slot 2 exception code 2, slot 1 misp → mask 4'b0011; RECOVER entered; the exception is not taken until slot 2 re-arrives.
- Exception in slot 0 with `stq_empty`=0 for 100 cycles → DRAIN; HALT with `drain_timeout`=1, `halt_code`=code. Repeat with `stq_empty` rising at cycle 5 → `drain_timeout`=0.
- `rst` asserted in DRAIN → next cycle RUN with all outputs 0. With `RETIRE_PERF_EN`, 10 cycles × 4 retires → `perf_instr_cnt`=40.

Source files
------------

// File: rtl/retire_ctrl_if.sv
// ROB head-window bundle between the reorder buffer and retire_ctrl.
// The ROB drives the window (master); retire_ctrl returns the retire mask and count (slave).
interface retire_ctrl_if #(
    parameter int W     = 4,
    parameter int EXC_W = 4
);
    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]            head_valid;
    logic [W-1:0]            head_complete;
    logic [W-1:0][EXC_W-1:0] head_exception;
    logic [W-1:0]            head_is_branch;
    logic [W-1:0]            head_branch_misp;
    logic [W-1:0]            head_is_store;
    logic [W-1:0]            retire_valid;
    logic [CNT_W-1:0]        retire_cnt;

    modport master (
        output head_valid, head_complete, head_exception,
               head_is_branch, head_branch_misp, head_is_store,
        input  retire_valid, retire_cnt
    );

    modport slave (
        input  head_valid, head_complete, head_exception,
               head_is_branch, head_branch_misp, head_is_store,
        output retire_valid, retire_cnt
    );
endinterface

// File: rtl/retire_ctrl.sv
// In-order commit scheduler: retire mask, mispredict recovery, exception drain/halt.
// Define RETIRE_PERF_EN to build the retired-instruction/branch/mispredict counters.
module retire_ctrl #(
    parameter int W             = 4,
    parameter int EXC_W         = 4,
    parameter int ST_PER_CYC    = 1,
    parameter int DRAIN_TIMEOUT = 100
) (
    input  logic                clk,
    input  logic                rst,
    retire_ctrl_if.slave        rob,
    input  logic                stq_retire_ready,
    input  logic                stq_empty,
    input  logic                flush_done,
    output logic                flush_req,
    output logic                halted,
    output logic [EXC_W-1:0]    halt_code,
    output logic                drain_timeout,
    output logic [63:0]         perf_instr_cnt,
    output logic [31:0]         perf_br_cnt,
    output logic [31:0]         perf_misp_cnt
);
    localparam int CNT_W = $clog2(W + 1);
    localparam int DC_W  = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_RECOVER = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    state_t           state_r;
    logic [DC_W-1:0]  drain_cnt_r;
    logic [W-1:0]     mask_s;
    logic [CNT_W-1:0] cnt_s;
    logic             exc_hit_s;
    logic             misp_hit_s;
    logic [EXC_W-1:0] exc_code_s;
    logic             stop_s;
    logic             ok_s;
    int               st_cnt_s;

    // Retire selection: walk the window from the head, stop at the first blocked or group-ending slot
    always_comb begin
        mask_s     = '0;
        cnt_s      = '0;
        exc_hit_s  = 1'b0;
        misp_hit_s = 1'b0;
        exc_code_s = '0;
        stop_s     = (state_r != ST_RUN) || rst;
        st_cnt_s   = 0;
        ok_s       = 1'b0;
        for (int i = 0; i < W; i++) begin
            ok_s = rob.head_valid[i] && rob.head_complete[i] &&
                   (!rob.head_is_store[i] || (stq_retire_ready && (st_cnt_s < ST_PER_CYC)));
            if (!stop_s && ok_s) begin
                mask_s[i] = 1'b1;
                cnt_s     = cnt_s + CNT_W'(1);
                st_cnt_s  = st_cnt_s + int'(rob.head_is_store[i]);
                if (rob.head_exception[i] != '0) begin
                    exc_hit_s  = 1'b1;
                    exc_code_s = rob.head_exception[i];
                    stop_s     = 1'b1;
                end else if (rob.head_is_branch[i] && rob.head_branch_misp[i]) begin
                    misp_hit_s = 1'b1;
                    stop_s     = 1'b1;
                end else begin
                    stop_s     = 1'b0;
                end
            end else begin
                stop_s = 1'b1;
            end
        end
    end

    assign rob.retire_valid = mask_s;
    assign rob.retire_cnt   = cnt_s;

    // Control FSM with registered status outputs; an exception outranks a mispredict in the same group
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_RUN;
            drain_cnt_r   <= '0;
            flush_req     <= 1'b0;
            halted        <= 1'b0;
            halt_code     <= '0;
            drain_timeout <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (exc_hit_s) begin
                        state_r     <= ST_DRAIN;
                        drain_cnt_r <= DC_W'(DRAIN_TIMEOUT);
                        halt_code   <= exc_code_s;
                    end else if (misp_hit_s) begin
                        state_r   <= ST_RECOVER;
                        flush_req <= 1'b1;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_RECOVER: begin
                    if (flush_done) begin
                        state_r   <= ST_RUN;
                        flush_req <= 1'b0;
                    end else begin
                        flush_req <= 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // An empty store queue wins over a simultaneous timeout
                    if (stq_empty) begin
                        state_r       <= ST_HALT;
                        halted        <= 1'b1;
                        drain_timeout <= 1'b0;
                    end else if (drain_cnt_r == '0) begin
                        state_r       <= ST_HALT;
                        halted        <= 1'b1;
                        drain_timeout <= 1'b1;
                    end else begin
                        drain_cnt_r <= drain_cnt_r - DC_W'(1);
                    end
                end
                ST_HALT: begin
                    halted <= 1'b1;
                end
                default: begin
                    state_r <= ST_RUN;
                end
            endcase
        end
    end

`ifdef RETIRE_PERF_EN
    logic [CNT_W-1:0] br_cnt_s;
    logic [CNT_W-1:0] misp_cnt_s;

    // Count retiring branches and retiring mispredicted branches
    always_comb begin
        br_cnt_s   = '0;
        misp_cnt_s = '0;
        for (int i = 0; i < W; i++) begin
            br_cnt_s   = br_cnt_s + CNT_W'(mask_s[i] & rob.head_is_branch[i]);
            misp_cnt_s = misp_cnt_s +
                         CNT_W'(mask_s[i] & rob.head_is_branch[i] & rob.head_branch_misp[i]);
        end
    end

    // Free-running performance counters, wrapping at their width
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_instr_cnt <= 64'd0;
            perf_br_cnt    <= 32'd0;
            perf_misp_cnt  <= 32'd0;
        end else begin
            perf_instr_cnt <= perf_instr_cnt + 64'(cnt_s);
            perf_br_cnt    <= perf_br_cnt + 32'(br_cnt_s);
            perf_misp_cnt  <= perf_misp_cnt + 32'(misp_cnt_s);
        end
    end
`else
    assign perf_instr_cnt = 64'd0;
    assign perf_br_cnt    = 32'd0;
    assign perf_misp_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_retire_ctrl.sv
// Directed self-checking bench for retire_ctrl (W=4, ST_PER_CYC=1, DRAIN_TIMEOUT=100).
module tb_retire_ctrl;
    localparam int W     = 4;
    localparam int EXC_W = 4;

    logic clk = 1'b0;
    logic rst;
    logic stq_retire_ready;
    logic stq_empty;
    logic flush_done;
    logic flush_req;
    logic halted;
    logic [EXC_W-1:0] halt_code;
    logic drain_timeout;
    logic [63:0] perf_instr_cnt;
    logic [31:0] perf_br_cnt;
    logic [31:0] perf_misp_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    retire_ctrl_if #(.W(W), .EXC_W(EXC_W)) rob ();

    retire_ctrl #(
        .W(W), .EXC_W(EXC_W), .ST_PER_CYC(1), .DRAIN_TIMEOUT(100)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rob              (rob),
        .stq_retire_ready (stq_retire_ready),
        .stq_empty        (stq_empty),
        .flush_done       (flush_done),
        .flush_req        (flush_req),
        .halted           (halted),
        .halt_code        (halt_code),
        .drain_timeout    (drain_timeout),
        .perf_instr_cnt   (perf_instr_cnt),
        .perf_br_cnt      (perf_br_cnt),
        .perf_misp_cnt    (perf_misp_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic win(input logic [3:0] v, input logic [3:0] c, input logic [3:0] st,
                       input logic [3:0] br, input logic [3:0] mp, input logic [15:0] exc);
        rob.head_valid       = v;
        rob.head_complete    = c;
        rob.head_is_store    = st;
        rob.head_is_branch   = br;
        rob.head_branch_misp = mp;
        rob.head_exception   = exc;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_mask(input string tag, input logic [3:0] m, input logic [2:0] n);
        chk({tag, "_mask"}, 64'(rob.retire_valid), 64'(m));
        chk({tag, "_cnt"}, 64'(rob.retire_cnt), 64'(n));
    endtask

    task automatic pulse_rst;
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        stq_retire_ready = 1'b1;
        stq_empty = 1'b1;
        flush_done = 1'b0;
        win(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000);
        tick;
        tick;
        chk_mask("reset", 4'h0, 3'd0);
        chk("reset_flush", 64'(flush_req), 64'd0);
        chk("reset_halted", 64'(halted), 64'd0);
        chk("reset_code", 64'(halt_code), 64'd0);
        chk("reset_tmo", 64'(drain_timeout), 64'd0);
        chk("reset_perf", perf_instr_cnt, 64'd0);

        // full-width retire
        rst = 1'b0;
        #1;
        chk_mask("all4", 4'hF, 3'd4);
        tick;
        chk_mask("all4_again", 4'hF, 3'd4);
        chk("all4_flush", 64'(flush_req), 64'd0);
        chk("all4_halted", 64'(halted), 64'd0);

        // store throttling and prefix boundaries
        win(4'hF, 4'hF, 4'b0111, 4'h0, 4'h0, 16'h0000);
        #1;
        chk_mask("st3_rdy", 4'b0001, 3'd1);
        stq_retire_ready = 1'b0;
        #1;
        chk_mask("st3_nrdy", 4'b0000, 3'd0);
        stq_retire_ready = 1'b1;
        win(4'hF, 4'hF, 4'b0010, 4'h0, 4'h0, 16'h0000);
        #1;
        chk_mask("st1", 4'hF, 3'd4);
        win(4'hF, 4'b1110, 4'h0, 4'h0, 4'h0, 16'h0000);
        #1;
        chk_mask("head_incomplete", 4'h0, 3'd0);
        win(4'b1011, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000);
        #1;
        chk_mask("hole_slot2", 4'b0011, 3'd2);

        // mispredict in slot 1, flush_done three cycles later
        tick;
        win(4'hF, 4'hF, 4'h0, 4'b0010, 4'b0010, 16'h0000);
        #1;
        chk_mask("misp", 4'b0011, 3'd2);
        tick;
        chk("rec1_flush", 64'(flush_req), 64'd1);
        chk_mask("rec1", 4'h0, 3'd0);
        tick;
        chk("rec2_flush", 64'(flush_req), 64'd1);
        tick;
        flush_done = 1'b1;
        #1;
        chk("rec3_flush", 64'(flush_req), 64'd1);
        chk_mask("rec3", 4'h0, 3'd0);
        tick;
        flush_done = 1'b0;
        win(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000);
        #1;
        chk("resume_flush", 64'(flush_req), 64'd0);
        chk_mask("resume", 4'hF, 3'd4);

        // exception in slot 2 behind a slot-1 mispredict: mispredict handled first
        win(4'hF, 4'hF, 4'h0, 4'b0010, 4'b0010, 16'h0200);
        #1;
        chk_mask("exc_behind_misp", 4'b0011, 3'd2);
        tick;
        flush_done = 1'b1;
        #1;
        chk("ebm_flush", 64'(flush_req), 64'd1);
        chk("ebm_code", 64'(halt_code), 64'd0);
        tick;
        flush_done = 1'b0;
        stq_empty = 1'b0;
        win(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0002);
        #1;
        chk_mask("exc_slot0", 4'b0001, 3'd1);

        // drain runs DRAIN_TIMEOUT+1 cycles before forced halt
        tick;
        chk_mask("drain1", 4'h0, 3'd0);
        chk("drain1_code", 64'(halt_code), 64'd2);
        chk("drain1_halted", 64'(halted), 64'd0);
        chk("drain1_flush", 64'(flush_req), 64'd0);
        repeat (100) tick;
        chk("drain101_halted", 64'(halted), 64'd0);
        tick;
        chk("tmo_halted", 64'(halted), 64'd1);
        chk("tmo_flag", 64'(drain_timeout), 64'd1);
        chk("tmo_code", 64'(halt_code), 64'd2);
        flush_done = 1'b1;
        tick;
        flush_done = 1'b0;
        chk("halt_sticky", 64'(halted), 64'd1);
        chk("halt_noflush", 64'(flush_req), 64'd0);
        chk_mask("halt", 4'h0, 3'd0);

        // same slot exception + mispredict: exception wins; drain ends early on stq_empty
        pulse_rst;
        win(4'hF, 4'hF, 4'h0, 4'b0001, 4'b0001, 16'h0005);
        #1;
        chk_mask("exc_misp", 4'b0001, 3'd1);
        tick;
        chk("em_flush", 64'(flush_req), 64'd0);
        chk("em_code", 64'(halt_code), 64'd5);
        repeat (4) tick;
        stq_empty = 1'b1;
        #1;
        chk("em_pre_halt", 64'(halted), 64'd0);
        tick;
        chk("em_halted", 64'(halted), 64'd1);
        chk("em_tmo", 64'(drain_timeout), 64'd0);

        // reset in the middle of a drain
        pulse_rst;
        stq_empty = 1'b0;
        win(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0003);
        tick;
        chk("rd_code", 64'(halt_code), 64'd3);
        tick;
        tick;
        rst = 1'b1;
        tick;
        chk_mask("rd_rst", 4'h0, 3'd0);
        chk("rd_code0", 64'(halt_code), 64'd0);
        chk("rd_halted0", 64'(halted), 64'd0);
        chk("rd_tmo0", 64'(drain_timeout), 64'd0);
        chk("rd_flush0", 64'(flush_req), 64'd0);
        rst = 1'b0;
        stq_empty = 1'b1;
        win(4'hF, 4'hF, 4'h0, 4'h0, 4'h0, 16'h0000);
        #1;
        chk_mask("rd_run", 4'hF, 3'd4);

        // performance counters: 10 cycles x 4 retires, 2 branches each
        pulse_rst;
        win(4'hF, 4'hF, 4'h0, 4'b0011, 4'h0, 16'h0000);
        repeat (10) tick;
        win(4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0000);
        #1;
`ifdef RETIRE_PERF_EN
        chk("perf_instr", perf_instr_cnt, 64'd40);
        chk("perf_br", 64'(perf_br_cnt), 64'd20);
        chk("perf_misp", 64'(perf_misp_cnt), 64'd0);
`else
        chk("perf_instr_off", perf_instr_cnt, 64'd0);
        chk("perf_br_off", 64'(perf_br_cnt), 64'd0);
        chk("perf_misp_off", 64'(perf_misp_cnt), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
